alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Registered, parametrised successor of the ALU operand mux. It decodes the immediate for all RV32 formats (I/S/B/U/J).
//  It resolves rs1/rs2 through N prioritised forwarding channels and selects ALU operands A and B.
//  Results are held in a valid/ready pipeline register between decode and the ALU.
//  It sits at the DCR->EX boundary and also carries forwarded rs2 as store data.
// PARAMETERS
//  XLEN     32  datapath width; immediates sign-extended to XLEN
//  FWD_CH   2   number of forwarding channels; channel 0 = youngest = highest priority
//  RADDR_W  5   register address width
// PORTS
//  clk            in   1                clock, rising edge
//  rst            in   1                asynchronous, active-high reset
//  DCR_valid      in   1                decode presents a valid operand request
//  MUX_ready      out  1                stage can accept; = !MUX_valid | EX_ready
//  DCR_flush      in   1                kill the held and incoming request
//  DCR_instr      in   32               raw instruction; immediate fields taken from it
//  DCR_imm_fmt    in   3                0=I 1=S 2=B 3=U 4=J; 5-7 -> imm=0
//  DCR_imm_sel    in   1                operand B: 1=imm, 0=rs2
//  DCR_a_sel      in   2                operand A: 0=rs1 1=PC 2=zero 3=rs1
//  DCR_pc         in   XLEN             PC of the instruction
//  DCR_rs1_addr   in   RADDR_W          rs1 index
//  DCR_rs2_addr   in   RADDR_W          rs2 index
//  RAW_rs1_val    in   XLEN             register-file rs1 read
//  RAW_rs2_val    in   XLEN             register-file rs2 read
//  FWD_valid      in   FWD_CH           per-channel writeback pending
//  FWD_rd_addr    in   FWD_CH*RADDR_W   per-channel destination, channel i at [i*RADDR_W +: RADDR_W]
//  FWD_data       in   FWD_CH*XLEN      per-channel result, channel i at [i*XLEN +: XLEN]
//  EX_ready       in   1                ALU consumes MUX_valid this cycle
//  MUX_valid      out  1                operands valid
//  MUX_op_a       out  XLEN             ALU operand A
//  MUX_op_b       out  XLEN             ALU operand B
//  MUX_store_val  out  XLEN             resolved rs2, for stores/branches
//  MUX_imm        out  XLEN             decoded immediate
// BEHAVIOUR
//  - Reset (async, any time):
//    - MUX_valid=0; MUX_op_a, MUX_op_b, MUX_store_val, MUX_imm = 0.
//    - An in-flight request is dropped, never emitted.
//  - Latency: one cycle. A request accepted on edge N is visible after edge N.
//  - Accept rule: DCR_valid & MUX_ready & !DCR_flush loads all output registers and sets MUX_valid.
//  - MUX_valid & EX_ready & no accept: clear MUX_valid. Data regs hold their last value.
//  - MUX_valid & !EX_ready: all outputs hold stable (stall). MUX_ready=0 is combinational.
//  - Simultaneous EX_ready and new accept: back-to-back, no bubble.
//  - DCR_flush: MUX_valid<=0 next edge, regardless of DCR_valid or EX_ready. Flush beats accept.
//  - Immediate decode, all sign bits from instr[31], extended to XLEN:
//    - I: instr[31:20]
//    - S: {instr[31:25], instr[11:7]}
//    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//    - U: {instr[31:12], 12'b0}
//    - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//  - Forwarding per source (rs1, rs2):
//    - Scan channels 0..FWD_CH-1. The first with FWD_valid[i] & rd_addr==src & src!=0 supplies the data.
//    - No hit: use the RAW_ value.
//    - Address 0 never forwards: value 0 is taken from RAW.
//  - Resolved values are captured at accept. Forwarding inputs during a stall do not alter held outputs.
//  - op_b = imm_sel ? imm : resolved rs2. store_val is always resolved rs2.
//  - All operand paths are combinational into the registers; there is no internal state besides the pipeline register.
// CONFIGURATION
//  ALU_OPERAND_TRACE_EN
//  - Defined: adds ports TRACE_imm_val (out, XLEN) and TRACE_fwd_hit (out, 2, {rs2_hit, rs1_hit}).
//    - Both are registered with the pipeline register; reset to 0.
//    - They hold during stall, same as the data outputs.
//  - Undefined: the ports and their registers are absent. Functional behaviour is identical.
// TESTING
//  1 Reset mid-stall: hold MUX_valid=1 with EX_ready=0, pulse rst -> MUX_valid=0 and all outputs 0 immediately, with no emission after release.
//  2 Immediate formats: instr=32'hFFF00093, fmt=I, imm_sel=1 -> MUX_imm=MUX_op_b=32'hFFFFFFFF. instr=32'h800000EF, fmt=J -> MUX_imm=32'hFFF00000.
//  3 Forward priority: rs1=5, FWD ch0{v=1,rd=5,data=0xAAAA}, ch1{v=1,rd=5,0xBBBB}, RAW=0x1111 -> op_a=0xAAAA. Clear ch0 -> 0xBBBB.
//  4 x0 guard: rs2=0, ch0{v=1,rd=0,data=0xDEAD}, imm_sel=0 -> op_b=0 and store_val=0.
//  5 Stall/back-to-back: EX_ready=0 for 3 cycles while forwarding data changes -> outputs unchanged, MUX_ready=0. Then EX_ready=1 with DCR_valid=1 -> the next request appears the following cycle, with no bubble.
//  6 Flush: DCR_valid=1, DCR_flush=1, EX_ready=1, MUX_valid=1 -> MUX_valid=0 next cycle. The flushed request is never seen.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: RV32 immediate decode, prioritised rs1/rs2 forwarding, operand A/B select.
// Optional trace outputs (TRACE_imm_val, TRACE_fwd_hit) are built when ALU_OPERAND_TRACE_EN is defined.
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int FWD_CH  = 2,
  parameter int RADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DCR_valid,
  output logic                      MUX_ready,
  input  logic                      DCR_flush,
  input  logic [31:0]               DCR_instr,
  input  logic [2:0]                DCR_imm_fmt,
  input  logic                      DCR_imm_sel,
  input  logic [1:0]                DCR_a_sel,
  input  logic [XLEN-1:0]           DCR_pc,
  input  logic [RADDR_W-1:0]        DCR_rs1_addr,
  input  logic [RADDR_W-1:0]        DCR_rs2_addr,
  input  logic [XLEN-1:0]           RAW_rs1_val,
  input  logic [XLEN-1:0]           RAW_rs2_val,
  input  logic [FWD_CH-1:0]         FWD_valid,
  input  logic [FWD_CH*RADDR_W-1:0] FWD_rd_addr,
  input  logic [FWD_CH*XLEN-1:0]    FWD_data,
  input  logic                      EX_ready,
  output logic                      MUX_valid,
  output logic [XLEN-1:0]           MUX_op_a,
  output logic [XLEN-1:0]           MUX_op_b,
  output logic [XLEN-1:0]           MUX_store_val,
  output logic [XLEN-1:0]           MUX_imm
`ifdef ALU_OPERAND_TRACE_EN
  ,
  output logic [XLEN-1:0]           TRACE_imm_val,
  output logic [1:0]                TRACE_fwd_hit
`endif
);

  function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] instr, input logic [2:0] fmt);
    logic signed [31:0] imm32;
    case (fmt)
      3'd0:    imm32 = {{20{instr[31]}}, instr[31:20]};
      3'd1:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3:    imm32 = {instr[31:12], 12'b0};
      3'd4:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'sd0;
    endcase
    return XLEN'(imm32);
  endfunction

  // Result is {hit, value}; scanning down lets the lowest (youngest) channel win.
  function automatic logic [XLEN:0] fwd_resolve(
    input logic [RADDR_W-1:0]        src,
    input logic [XLEN-1:0]           raw,
    input logic [FWD_CH-1:0]         fv,
    input logic [FWD_CH*RADDR_W-1:0] frd,
    input logic [FWD_CH*XLEN-1:0]    fdata
  );
    logic [XLEN:0] res;
    res = {1'b0, raw};
    for (int i = FWD_CH - 1; i >= 0; i--) begin
      res = (fv[i] && (frd[i*RADDR_W +: RADDR_W] == src) && (src != {RADDR_W{1'b0}}))
            ? {1'b1, fdata[i*XLEN +: XLEN]} : res;
    end
    return res;
  endfunction

  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      op_a_q, op_a_d;
  logic [XLEN-1:0]      op_b_q, op_b_d;
  logic [XLEN-1:0]      store_q, store_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [1:0]           hit_q, hit_d;
  logic [XLEN:0]        rs1_fwd_s, rs2_fwd_s;
  logic [XLEN-1:0]      imm_s, op_a_s, op_b_s;
  logic                 accept_s;
  logic                 unused_opcode_s;

  assign unused_opcode_s = ^DCR_instr[6:0];
  assign MUX_ready       = ~valid_q | EX_ready;
  assign accept_s        = DCR_valid & MUX_ready & ~DCR_flush;

  // Operand resolution for the incoming request
  always_comb begin
    rs1_fwd_s = fwd_resolve(DCR_rs1_addr, RAW_rs1_val, FWD_valid, FWD_rd_addr, FWD_data);
    rs2_fwd_s = fwd_resolve(DCR_rs2_addr, RAW_rs2_val, FWD_valid, FWD_rd_addr, FWD_data);
    imm_s     = imm_decode(DCR_instr, DCR_imm_fmt);
    case (DCR_a_sel)
      2'd1:    op_a_s = DCR_pc;
      2'd2:    op_a_s = {XLEN{1'b0}};
      default: op_a_s = rs1_fwd_s[XLEN-1:0];
    endcase
    if (DCR_imm_sel) begin
      op_b_s = imm_s;
    end else begin
      op_b_s = rs2_fwd_s[XLEN-1:0];
    end
  end

  // Pipeline register next state: flush beats accept, accept beats drain
  always_comb begin
    valid_d = valid_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    store_d = store_q;
    imm_d   = imm_q;
    hit_d   = hit_q;
    if (DCR_flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      op_a_d  = op_a_s;
      op_b_d  = op_b_s;
      store_d = rs2_fwd_s[XLEN-1:0];
      imm_d   = imm_s;
      hit_d   = {rs2_fwd_s[XLEN], rs1_fwd_s[XLEN]};
    end else if (valid_q && EX_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_a_q  <= {XLEN{1'b0}};
      op_b_q  <= {XLEN{1'b0}};
      store_q <= {XLEN{1'b0}};
      imm_q   <= {XLEN{1'b0}};
      hit_q   <= 2'b00;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      store_q <= store_d;
      imm_q   <= imm_d;
      hit_q   <= hit_d;
    end
  end

  assign MUX_valid     = valid_q;
  assign MUX_op_a      = op_a_q;
  assign MUX_op_b      = op_b_q;
  assign MUX_store_val = store_q;
  assign MUX_imm       = imm_q;

`ifdef ALU_OPERAND_TRACE_EN
  assign TRACE_imm_val = imm_q;
  assign TRACE_fwd_hit = hit_q;
`else
  logic unused_hit_s;
  assign unused_hit_s = ^hit_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (default XLEN=32, FWD_CH=2, RADDR_W=5).
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        DCR_valid, DCR_flush, DCR_imm_sel, EX_ready;
  logic        MUX_ready, MUX_valid;
  logic [31:0] DCR_instr, DCR_pc, RAW_rs1_val, RAW_rs2_val;
  logic [2:0]  DCR_imm_fmt;
  logic [1:0]  DCR_a_sel, FWD_valid;
  logic [4:0]  DCR_rs1_addr, DCR_rs2_addr;
  logic [9:0]  FWD_rd_addr;
  logic [63:0] FWD_data;
  logic [31:0] MUX_op_a, MUX_op_b, MUX_store_val, MUX_imm;
`ifdef ALU_OPERAND_TRACE_EN
  logic [31:0] TRACE_imm_val;
  logic [1:0]  TRACE_fwd_hit;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .DCR_valid(DCR_valid), .MUX_ready(MUX_ready), .DCR_flush(DCR_flush),
    .DCR_instr(DCR_instr), .DCR_imm_fmt(DCR_imm_fmt), .DCR_imm_sel(DCR_imm_sel),
    .DCR_a_sel(DCR_a_sel), .DCR_pc(DCR_pc), .DCR_rs1_addr(DCR_rs1_addr),
    .DCR_rs2_addr(DCR_rs2_addr), .RAW_rs1_val(RAW_rs1_val), .RAW_rs2_val(RAW_rs2_val),
    .FWD_valid(FWD_valid), .FWD_rd_addr(FWD_rd_addr), .FWD_data(FWD_data),
    .EX_ready(EX_ready), .MUX_valid(MUX_valid), .MUX_op_a(MUX_op_a), .MUX_op_b(MUX_op_b),
    .MUX_store_val(MUX_store_val), .MUX_imm(MUX_imm)
`ifdef ALU_OPERAND_TRACE_EN
    , .TRACE_imm_val(TRACE_imm_val), .TRACE_fwd_hit(TRACE_fwd_hit)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; DCR_valid = 1'b0; DCR_flush = 1'b0; DCR_imm_sel = 1'b0; EX_ready = 1'b1;
    DCR_instr = 32'h0; DCR_imm_fmt = 3'd0; DCR_a_sel = 2'd0; DCR_pc = 32'h0;
    DCR_rs1_addr = 5'd0; DCR_rs2_addr = 5'd0; RAW_rs1_val = 32'h0; RAW_rs2_val = 32'h0;
    FWD_valid = 2'b00; FWD_rd_addr = 10'h0; FWD_data = 64'h0;
    #12;
    chk("reset_valid", {31'b0, MUX_valid}, 32'h0);
    chk("reset_ready", {31'b0, MUX_ready}, 32'h1);
    chk("reset_op_a", MUX_op_a, 32'h0);
    rst = 1'b0;

    // I-format immediate onto op_b; rs1=x0 reads RAW
    DCR_valid = 1'b1; DCR_instr = 32'hFFF00093; DCR_imm_fmt = 3'd0; DCR_imm_sel = 1'b1;
    RAW_rs1_val = 32'h12345678;
    tick();
    chk("imm_I_valid", {31'b0, MUX_valid}, 32'h1);
    chk("imm_I", MUX_imm, 32'hFFFFFFFF);
    chk("imm_I_op_b", MUX_op_b, 32'hFFFFFFFF);
    chk("imm_I_op_a", MUX_op_a, 32'h12345678);

    // J-format, op_a = PC
    DCR_instr = 32'h800000EF; DCR_imm_fmt = 3'd4; DCR_a_sel = 2'd1; DCR_pc = 32'h00001000;
    tick();
    chk("imm_J", MUX_imm, 32'hFFF00000);
    chk("imm_J_op_a_pc", MUX_op_a, 32'h00001000);

    // S-format, op_a = zero
    DCR_instr = 32'h80000FA3; DCR_imm_fmt = 3'd1; DCR_a_sel = 2'd2;
    tick();
    chk("imm_S", MUX_imm, 32'hFFFFF81F);
    chk("op_a_zero", MUX_op_a, 32'h0);

    DCR_instr = 32'h00000F63; DCR_imm_fmt = 3'd2;
    tick();
    chk("imm_B", MUX_imm, 32'h0000001E);

    DCR_instr = 32'hABCDE037; DCR_imm_fmt = 3'd3; DCR_a_sel = 2'd3; RAW_rs1_val = 32'h0000CAFE;
    tick();
    chk("imm_U", MUX_imm, 32'hABCDE000);
    chk("op_a_sel3_rs1", MUX_op_a, 32'h0000CAFE);

    DCR_imm_fmt = 3'd5;
    tick();
    chk("imm_fmt5", MUX_imm, 32'h0);

    // Forwarding priority on rs1
    DCR_a_sel = 2'd0; DCR_imm_sel = 1'b0; DCR_rs1_addr = 5'd5; RAW_rs1_val = 32'h00001111;
    FWD_valid = 2'b11; FWD_rd_addr = {5'd5, 5'd5}; FWD_data = {32'h0000BBBB, 32'h0000AAAA};
    tick();
    chk("fwd_ch0_wins", MUX_op_a, 32'h0000AAAA);
    FWD_valid = 2'b10;
    tick();
    chk("fwd_ch1", MUX_op_a, 32'h0000BBBB);
    FWD_valid = 2'b00;
    tick();
    chk("fwd_none_raw", MUX_op_a, 32'h00001111);

    // rs1 from ch0, rs2 from ch1
    FWD_valid = 2'b11; FWD_rd_addr = {5'd7, 5'd5}; DCR_rs2_addr = 5'd7; RAW_rs2_val = 32'h00002222;
    tick();
    chk("fwd_rs2_op_b", MUX_op_b, 32'h0000BBBB);
    chk("fwd_rs2_store", MUX_store_val, 32'h0000BBBB);
    chk("fwd_rs1_split", MUX_op_a, 32'h0000AAAA);

    // x0 never forwards
    DCR_rs2_addr = 5'd0; RAW_rs2_val = 32'h0; FWD_valid = 2'b01; FWD_rd_addr = {5'd0, 5'd0};
    FWD_data = {32'h0, 32'h0000DEAD};
    tick();
    chk("x0_op_b", MUX_op_b, 32'h0);
    chk("x0_store", MUX_store_val, 32'h0);

    // Stall: load R1, then hold with changing forward data
    DCR_rs1_addr = 5'd3; FWD_valid = 2'b01; FWD_rd_addr = {5'd0, 5'd3}; FWD_data = {32'h0, 32'h00003333};
    tick();
    chk("stall_load", MUX_op_a, 32'h00003333);
    EX_ready = 1'b0; FWD_data = {32'h0, 32'h00009999};
    #1;
    chk("stall_ready_low", {31'b0, MUX_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_a", MUX_op_a, 32'h00003333);
      chk("stall_valid", {31'b0, MUX_valid}, 32'h1);
      chk("stall_ready", {31'b0, MUX_ready}, 32'h0);
    end
    EX_ready = 1'b1;
    #1;
    chk("b2b_ready", {31'b0, MUX_ready}, 32'h1);
    tick();
    chk("b2b_valid", {31'b0, MUX_valid}, 32'h1);
    chk("b2b_op_a", MUX_op_a, 32'h00009999);

    // Drain without new request: valid clears, data holds
    DCR_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, MUX_valid}, 32'h0);
    chk("drain_hold", MUX_op_a, 32'h00009999);

    // Flush beats accept
    DCR_valid = 1'b1; DCR_rs1_addr = 5'd0; RAW_rs1_val = 32'h00004444; FWD_valid = 2'b00;
    tick();
    chk("pre_flush_valid", {31'b0, MUX_valid}, 32'h1);
    DCR_flush = 1'b1; RAW_rs1_val = 32'h00007777;
    tick();
    chk("flush_valid", {31'b0, MUX_valid}, 32'h0);
    chk("flush_no_load", MUX_op_a, 32'h00004444);
    DCR_flush = 1'b0; DCR_valid = 1'b0;
    tick();
    chk("flush_never_seen", {31'b0, MUX_valid}, 32'h0);

    // Reset mid-stall
    DCR_valid = 1'b1; DCR_instr = 32'hFFF00093; DCR_imm_fmt = 3'd0; RAW_rs1_val = 32'h00005555;
    RAW_rs2_val = 32'h00002222;
    tick();
    EX_ready = 1'b0; DCR_valid = 1'b0;
    tick();
    chk("rst_stall_valid", {31'b0, MUX_valid}, 32'h1);
    chk("rst_stall_imm", MUX_imm, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, MUX_valid}, 32'h0);
    chk("rst_async_op_a", MUX_op_a, 32'h0);
    chk("rst_async_op_b", MUX_op_b, 32'h0);
    chk("rst_async_store", MUX_store_val, 32'h0);
    chk("rst_async_imm", MUX_imm, 32'h0);
    #2 rst = 1'b0;
    tick();
    chk("rst_no_emit", {31'b0, MUX_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
